// File: rtl/sixstep_commutation_pwm.sv
// Six-step (trapezoidal) commutation with edge-aligned PWM on the high-side phase.
// Produces the 3-bit phase switch word and per-phase enables from the rotor angle.
// The commutation sector, duty and direction are latched at the PWM period boundary.
// Optional feature macro: DEADTIME_EN. When it is defined, all phases are blanked
// for min(DEAD_CYCLES, PWM_PERIOD) cycles after the sector or direction changes.
module sixstep_commutation_pwm #(
    parameter int unsigned PWM_PERIOD  = 1000,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        direction,
    input  logic [15:0] position,
    input  logic [15:0] duty,
    input  logic        fault,
    input  logic        fault_clr,
    output logic [2:0]  V_phase,
    output logic [2:0]  phase_en,
    output logic [2:0]  sector,
    output logic        period_start,
    output logic        fault_latched
);

    localparam int unsigned CW       = 16;
    localparam logic [CW-1:0] CNT_MAX  = CW'(PWM_PERIOD - 1);
    localparam logic [CW-1:0] DUTY_MAX = CW'(PWM_PERIOD);

    logic [CW-1:0] cnt;
    logic [CW-1:0] duty_sh;
    logic          dir_sh;
    logic          running;

    logic          wrap_c;
    logic [CW-1:0] cnt_nxt_c;
    logic [2:0]    raw_sector_c;
    logic [2:0]    sector_nxt_c;
    logic [CW-1:0] duty_nxt_c;
    logic          dir_nxt_c;
    logic          running_nxt_c;
    logic          fault_nxt_c;
    logic          blank_act_c;
    logic [2:0]    hi_c;
    logic [2:0]    lo_c;
    logic [2:0]    v_nxt_c;
    logic [2:0]    en_nxt_c;

`ifdef DEADTIME_EN
    localparam logic [CW-1:0] DEAD_LIM =
        CW'((DEAD_CYCLES < PWM_PERIOD) ? DEAD_CYCLES : PWM_PERIOD);

    logic blank;
    logic blank_nxt_c;

    // Blanking is armed for the whole period that follows a sector/direction change
    always_comb begin
        blank_nxt_c = blank;
        if (wrap_c) begin
            blank_nxt_c = (raw_sector_c != sector) || (direction != dir_sh);
        end
        blank_act_c = blank_nxt_c && (cnt_nxt_c < DEAD_LIM);
    end

    // Blanking flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank <= 1'b0;
        end else begin
            blank <= blank_nxt_c;
        end
    end
`else
    logic unused_dead_c;

    // Commutation is instantaneous; the dead-time length has no effect
    always_comb begin
        blank_act_c   = 1'b0;
        unused_dead_c = |32'(DEAD_CYCLES);
    end
`endif

    // Counter, sector decode, shadow loads and fault/run next state
    always_comb begin
        wrap_c       = (cnt == CNT_MAX);
        cnt_nxt_c    = wrap_c ? '0 : cnt + CW'(1);
        raw_sector_c = 3'((19'(position) * 19'd6) >> 16);
        fault_nxt_c  = fault | (fault_latched & ~fault_clr);

        sector_nxt_c  = sector;
        duty_nxt_c    = duty_sh;
        dir_nxt_c     = dir_sh;
        running_nxt_c = running & enable & ~fault;

        if (wrap_c) begin
            sector_nxt_c  = raw_sector_c;
            duty_nxt_c    = (duty > DUTY_MAX) ? DUTY_MAX : duty;
            dir_nxt_c     = direction;
            running_nxt_c = enable & ~fault & ~fault_latched;
        end
    end

    // Commutation table and PWM window for the upcoming cycle
    always_comb begin
        hi_c     = 3'b000;
        lo_c     = 3'b000;
        v_nxt_c  = 3'b000;
        en_nxt_c = 3'b000;

        case (sector_nxt_c)
            3'd0:    begin hi_c = 3'b001; lo_c = 3'b010; end
            3'd1:    begin hi_c = 3'b001; lo_c = 3'b100; end
            3'd2:    begin hi_c = 3'b010; lo_c = 3'b100; end
            3'd3:    begin hi_c = 3'b010; lo_c = 3'b001; end
            3'd4:    begin hi_c = 3'b100; lo_c = 3'b001; end
            3'd5:    begin hi_c = 3'b100; lo_c = 3'b010; end
            default: begin hi_c = 3'b000; lo_c = 3'b000; end
        endcase

        if (dir_nxt_c) begin
            {hi_c, lo_c} = {lo_c, hi_c};
        end

        if (running_nxt_c && !blank_act_c) begin
            en_nxt_c = hi_c | lo_c;
            if (cnt_nxt_c < duty_nxt_c) begin
                v_nxt_c = hi_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            duty_sh       <= '0;
            dir_sh        <= 1'b0;
            running       <= 1'b0;
            sector        <= 3'd0;
            fault_latched <= 1'b0;
            period_start  <= 1'b0;
            V_phase       <= 3'b000;
            phase_en      <= 3'b000;
        end else begin
            cnt           <= cnt_nxt_c;
            duty_sh       <= duty_nxt_c;
            dir_sh        <= dir_nxt_c;
            running       <= running_nxt_c;
            sector        <= sector_nxt_c;
            fault_latched <= fault_nxt_c;
            period_start  <= wrap_c;
            V_phase       <= v_nxt_c;
            phase_en      <= en_nxt_c;
        end
    end

endmodule

// File: tb/tb_sixstep_commutation_pwm.sv
// Bench for sixstep_commutation_pwm: directed test-plan steps followed by random
// stimulus, all checked cycle by cycle against a behavioural model.
module tb_sixstep_commutation_pwm;

    localparam int unsigned P  = 10;
    localparam int unsigned D  = 3;
    localparam int unsigned DL = (D < P) ? D : P;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        direction;
    logic [15:0] position;
    logic [15:0] duty;
    logic        fault;
    logic        fault_clr;
    logic [2:0]  V_phase;
    logic [2:0]  phase_en;
    logic [2:0]  sector;
    logic        period_start;
    logic        fault_latched;

    sixstep_commutation_pwm #(
        .PWM_PERIOD  (P),
        .DEAD_CYCLES (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .direction     (direction),
        .position      (position),
        .duty          (duty),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .V_phase       (V_phase),
        .phase_en      (phase_en),
        .sector        (sector),
        .period_start  (period_start),
        .fault_latched (fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: which phase is the high side / low side per forward sector
    int hi_tab [6] = '{0, 0, 1, 1, 2, 2};
    int lo_tab [6] = '{1, 2, 2, 0, 0, 1};

    int m_cnt, m_sec, m_duty;
    bit m_dir, m_run, m_flt, m_blank, m_ps;

    // Advance the model one clock, then compare against the DUT just after the edge
    always @(posedge clk) begin
        int new_sec;
        int h, l;
        logic [2:0] exp_v, exp_en;
        if (rst) begin
            m_cnt = 0; m_sec = 0; m_duty = 0;
            m_dir = 0; m_run = 0; m_flt = 0; m_blank = 0; m_ps = 0;
        end else begin
            if (m_cnt == int'(P) - 1) begin
                new_sec = (int'(position) * 6) / 65536;
                m_blank = (new_sec != m_sec) || (direction != m_dir);
                m_sec   = new_sec;
                m_duty  = (int'(duty) > int'(P)) ? int'(P) : int'(duty);
                m_dir   = direction;
                m_run   = enable && !fault && !m_flt;
                m_cnt   = 0;
            end else begin
                m_run = m_run && enable && !fault;
                m_cnt = m_cnt + 1;
            end
            m_ps  = (m_cnt == 0);
            m_flt = fault ? 1'b1 : (fault_clr ? 1'b0 : m_flt);
        end

        if (chk_on) begin
            #1;
            exp_v  = 3'b000;
            exp_en = 3'b000;
            if (m_run) begin
                h = m_dir ? lo_tab[m_sec] : hi_tab[m_sec];
                l = m_dir ? hi_tab[m_sec] : lo_tab[m_sec];
                exp_en = 3'((1 << h) | (1 << l));
                if (m_cnt < m_duty) exp_v = 3'(1 << h);
            end
`ifdef DEADTIME_EN
            if (m_blank && m_cnt < int'(DL)) begin
                exp_v  = 3'b000;
                exp_en = 3'b000;
            end
`endif
            check("v_phase",       16'(V_phase),       16'(exp_v));
            check("phase_en",      16'(phase_en),      16'(exp_en));
            check("sector",        16'(sector),        16'(m_sec));
            check("period_start",  16'(period_start),  16'(m_ps));
            check("fault_latched", 16'(fault_latched), 16'(m_flt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; direction = 1'b0;
        position = 16'h0000; duty = 16'd0; fault = 1'b0; fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_v_phase",       16'(V_phase),       16'd0);
        check("rst_phase_en",      16'(phase_en),      16'd0);
        check("rst_sector",        16'(sector),        16'd0);
        check("rst_period_start",  16'(period_start),  16'd0);
        check("rst_fault_latched", 16'(fault_latched), 16'd0);

        @(negedge clk);
        rst    = 1'b0;
        chk_on = 1'b1;

        // Idle with enable low
        step(25);
        // Forward drive in sector 0
        position = 16'h0000; duty = 16'd4; enable = 1'b1; direction = 1'b0;
        step(33);
        // Mid-period sector change, then top of range
        position = 16'h3000;
        step(25);
        position = 16'hFFFF;
        step(20);
        // Duty clamp and zero duty in sector 0
        position = 16'h0000; duty = 16'd15;
        step(20);
        duty = 16'd0;
        step(20);
        // Reverse direction
        duty = 16'd4; direction = 1'b1;
        step(20);
        // Fault, clear ignored while fault high, then a real clear
        direction = 1'b0;
        step(4);
        fault = 1'b1;
        step(1);
        fault_clr = 1'b1;
        step(1);
        fault = 1'b0; fault_clr = 1'b0;
        step(6);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        step(25);
        // Sector 0 -> 1 transition with duty 5
        duty = 16'd5; position = 16'h0000;
        step(20);
        position = 16'h3000;
        step(30);
        // Enable drop mid-period and restart
        step(3);
        enable = 1'b0;
        step(4);
        enable = 1'b1;
        step(25);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  position  = 16'($urandom);
            if ($urandom_range(0, 19) == 0) duty      = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) direction = ~direction;
            if ($urandom_range(0, 39) == 0) enable    = ($urandom_range(0, 3) != 0);
            fault     = ($urandom_range(0, 149) == 0);
            fault_clr = ($urandom_range(0, 19) == 0);
            step(1);
        end

        fault = 1'b0; fault_clr = 1'b0;
        step(2);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
